// File: rtl/mx_block_unpacker.sv
// Streams one MX scaling block (shared E8M0 scale + BLOCK_SIZE elements) as LANES-wide beats.
// Optional pending-block skid buffer for bubble-free back-to-back blocks: define MX_UNPACK_SKID_EN.
module mx_block_unpacker #(
  parameter int ELEM_BITS  = 8,
  parameter int BLOCK_SIZE = 32,
  parameter int LANES      = 4,
  localparam int NBEATS    = BLOCK_SIZE / LANES,
  localparam int BW        = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0]                    in_scale,
  input  logic [BLOCK_SIZE*ELEM_BITS-1:0] in_elements,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*ELEM_BITS-1:0]    out_elements,
  output logic [7:0]                    out_scale,
  output logic                          out_scale_nan,
  output logic                          out_first,
  output logic                          out_last,
  output logic [BW-1:0]                 out_beat_idx
);

  localparam int BLK_W = BLOCK_SIZE * ELEM_BITS;
  localparam int BEAT_W = LANES * ELEM_BITS;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} state_t;

  // E8M0 reserves the all-ones encoding for NaN
  function automatic logic scale_is_nan(input logic [7:0] s);
    return (s == 8'hFF);
  endfunction

  state_t             state_r, state_nx;
  logic [BW-1:0]      beat_r, beat_nx;
  logic [BLK_W-1:0]   act_elems_r, act_elems_nx;
  logic [7:0]         act_scale_r, act_scale_nx;
  logic               in_ready_r, in_ready_nx;
  logic               out_valid_r, out_valid_nx;
  logic [BEAT_W-1:0]  out_elements_r, out_elements_nx;
  logic [7:0]         out_scale_r;
  logic               out_scale_nan_r;
  logic               out_first_r, out_first_nx;
  logic               out_last_r, out_last_nx;
  logic               in_fire_s, out_fire_s, last_fire_s;
`ifdef MX_UNPACK_SKID_EN
  logic               pend_valid_r, pend_valid_nx;
  logic [BLK_W-1:0]   pend_elems_r, pend_elems_nx;
  logic [7:0]         pend_scale_r, pend_scale_nx;
`endif

  // Next-state, buffer steering and next output values
  always_comb begin
    state_nx     = state_r;
    beat_nx      = beat_r;
    act_elems_nx = act_elems_r;
    act_scale_nx = act_scale_r;
`ifdef MX_UNPACK_SKID_EN
    pend_valid_nx = pend_valid_r;
    pend_elems_nx = pend_elems_r;
    pend_scale_nx = pend_scale_r;
`endif
    in_fire_s   = in_valid && in_ready_r;
    out_fire_s  = out_valid_r && out_ready;
    last_fire_s = out_fire_s && (beat_r == LAST_BEAT);

    case (state_r)
      IDLE: begin
        if (in_fire_s) begin
          act_elems_nx = in_elements;
          act_scale_nx = in_scale;
          beat_nx      = {BW{1'b0}};
          state_nx     = STREAM;
        end else begin
          state_nx = IDLE;
        end
      end
      STREAM: begin
        if (last_fire_s) begin
          beat_nx = {BW{1'b0}};
`ifdef MX_UNPACK_SKID_EN
          if (pend_valid_r) begin
            act_elems_nx  = pend_elems_r;
            act_scale_nx  = pend_scale_r;
            pend_valid_nx = 1'b0;
          end else if (in_fire_s) begin
            act_elems_nx = in_elements;
            act_scale_nx = in_scale;
          end else begin
            state_nx = IDLE;
          end
`else
          state_nx = IDLE;
`endif
        end else if (out_fire_s) begin
          beat_nx = beat_r + BW'(1);
        end else begin
          beat_nx = beat_r;
        end
`ifdef MX_UNPACK_SKID_EN
        // A block arriving mid-stream parks in pending unless it went straight to active
        if (in_fire_s && !(last_fire_s && !pend_valid_r)) begin
          pend_elems_nx = in_elements;
          pend_scale_nx = in_scale;
          pend_valid_nx = 1'b1;
        end else begin
          pend_valid_nx = pend_valid_nx;
        end
`endif
      end
      default: begin
        state_nx = IDLE;
        beat_nx  = {BW{1'b0}};
      end
    endcase

`ifdef MX_UNPACK_SKID_EN
    in_ready_nx = !pend_valid_nx;
`else
    in_ready_nx = (state_nx == IDLE);
`endif
    out_valid_nx    = (state_nx == STREAM);
    out_first_nx    = out_valid_nx && (beat_nx == {BW{1'b0}});
    out_last_nx     = out_valid_nx && (beat_nx == LAST_BEAT);
    out_elements_nx = act_elems_nx[int'(beat_nx) * BEAT_W +: BEAT_W];
  end

  // State, buffers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= IDLE;
      beat_r          <= {BW{1'b0}};
      act_elems_r     <= {BLK_W{1'b0}};
      act_scale_r     <= 8'h00;
      in_ready_r      <= 1'b0;
      out_valid_r     <= 1'b0;
      out_elements_r  <= {BEAT_W{1'b0}};
      out_scale_r     <= 8'h00;
      out_scale_nan_r <= 1'b0;
      out_first_r     <= 1'b0;
      out_last_r      <= 1'b0;
`ifdef MX_UNPACK_SKID_EN
      pend_valid_r    <= 1'b0;
      pend_elems_r    <= {BLK_W{1'b0}};
      pend_scale_r    <= 8'h00;
`endif
    end else begin
      state_r         <= state_nx;
      beat_r          <= beat_nx;
      act_elems_r     <= act_elems_nx;
      act_scale_r     <= act_scale_nx;
      in_ready_r      <= in_ready_nx;
      out_valid_r     <= out_valid_nx;
      out_elements_r  <= out_elements_nx;
      out_scale_r     <= act_scale_nx;
      out_scale_nan_r <= scale_is_nan(act_scale_nx);
      out_first_r     <= out_first_nx;
      out_last_r      <= out_last_nx;
`ifdef MX_UNPACK_SKID_EN
      pend_valid_r    <= pend_valid_nx;
      pend_elems_r    <= pend_elems_nx;
      pend_scale_r    <= pend_scale_nx;
`endif
    end
  end

  assign in_ready      = in_ready_r;
  assign out_valid     = out_valid_r;
  assign out_elements  = out_elements_r;
  assign out_scale     = out_scale_r;
  assign out_scale_nan = out_scale_nan_r;
  assign out_first     = out_first_r;
  assign out_last      = out_last_r;
  assign out_beat_idx  = beat_r;

endmodule

// File: tb/tb_mx_block_unpacker.sv
// Scoreboard bench for mx_block_unpacker: default 8x4 configuration plus a single-beat
// 4-bit/32-lane instance. Honors MX_UNPACK_SKID_EN for the back-to-back timing checks.
module tb_mx_block_unpacker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]   in_scale, out_scale;
  logic [255:0] in_elements;
  logic [31:0]  out_elements;
  logic         out_scale_nan, out_first, out_last;
  logic [2:0]   out_beat_idx;

  logic         w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [7:0]   w_in_scale, w_out_scale;
  logic [127:0] w_in_elements, w_out_elements;
  logic         w_out_scale_nan, w_out_first, w_out_last;
  logic [0:0]   w_out_beat_idx;

  mx_block_unpacker dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_scale(in_scale), .in_elements(in_elements), .out_valid(out_valid),
    .out_ready(out_ready), .out_elements(out_elements), .out_scale(out_scale),
    .out_scale_nan(out_scale_nan), .out_first(out_first), .out_last(out_last),
    .out_beat_idx(out_beat_idx)
  );

  mx_block_unpacker #(.ELEM_BITS(4), .BLOCK_SIZE(32), .LANES(32)) dut_wide (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_scale(w_in_scale), .in_elements(w_in_elements), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .out_elements(w_out_elements), .out_scale(w_out_scale),
    .out_scale_nan(w_out_scale_nan), .out_first(w_out_first), .out_last(w_out_last),
    .out_beat_idx(w_out_beat_idx)
  );

  typedef struct packed {
    logic [31:0] elems;
    logic [7:0]  scale;
    logic        nan;
    logic        first;
    logic        last;
    logic [2:0]  idx;
  } beat_t;

  beat_t exp_q[$];
  int    hs_cycs[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_err = 0;

  // Scoreboard: every output handshake pops and checks one expected beat
  always @(negedge clk) begin
    beat_t e, got;
    cyc = cyc + 1;
    if (!rst && out_valid && out_ready) begin
      hs_cycs.push_back(cyc);
      got = {out_elements, out_scale, out_scale_nan, out_first, out_last, out_beat_idx};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_beat got=%h expected=none", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_err++;
          $display("FAIL beat_content got=%h expected=%h", got, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout cycles=%0d expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic send_block(input logic [7:0] sc, input int base);
    logic [255:0] blk;
    beat_t        e;
    bit           acc;
    for (int i = 0; i < 32; i++) blk[i*8 +: 8] = 8'(base + i);
    for (int k = 0; k < 8; k++) begin
      e.elems = {8'(base + 4*k + 3), 8'(base + 4*k + 2), 8'(base + 4*k + 1), 8'(base + 4*k)};
      e.scale = sc;
      e.nan   = (sc == 8'hFF);
      e.first = (k == 0);
      e.last  = (k == 7);
      e.idx   = 3'(k);
      exp_q.push_back(e);
    end
    in_scale    = sc;
    in_elements = blk;
    in_valid    = 1'b1;
    acc = 1'b0;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        acc = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout got=no_accept expected=accept");
    end
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout got=%0d_pending expected=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_scale = 8'h00; in_elements = '0;
    w_in_valid = 1'b0; w_out_ready = 1'b1; w_in_scale = 8'h00; w_in_elements = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, in_ready, out_first, out_last, w_out_valid, w_in_ready} !== 6'b000000) begin
      n_err++;
      $display("FAIL reset_state got=%b expected=000000",
               {out_valid, in_ready, out_first, out_last, w_out_valid, w_in_ready});
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, w_in_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL ready_after_reset got=%b expected=11", {in_ready, w_in_ready});
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send_block(8'h7F, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid, out_beat_idx, out_first, out_last} !== {1'b1, 3'(k), k == 0, k == 7}) begin
        n_err++;
        $display("FAIL basic_beat%0d got=%b expected=%b", k,
                 {out_valid, out_beat_idx, out_first, out_last}, {1'b1, 3'(k), k == 0, k == 7});
      end
      if (k == 0 || k == 7) begin
        n_cmp++;
        if (out_elements !== ((k == 0) ? 32'h03020100 : 32'h1F1E1D1C)) begin
          n_err++;
          $display("FAIL basic_elems%0d got=%h expected=%h", k, out_elements,
                   (k == 0) ? 32'h03020100 : 32'h1F1E1D1C);
        end
      end
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_idle_after got=%b expected=0", out_valid);
    end
    wait_drain();
  endtask

  task automatic test_stall();
    int   cnt = 0, s2 = 0, s5 = 0;
    bit   done = 1'b0, have_prev = 1'b0, prev_ready = 1'b1;
    logic [48:0] snap, now;
    send_block(8'h7F, 0);
    for (int t = 0; t < 60 && !done; t++) begin
      if (out_valid && out_beat_idx == 3'd2 && s2 < 3) begin
        out_ready = 1'b0; s2++;
      end else if (out_valid && out_beat_idx == 3'd5 && s5 < 3) begin
        out_ready = 1'b0; s5++;
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      cnt++;
      now = {out_valid, out_elements, out_scale, out_scale_nan, out_first, out_last, out_beat_idx};
      if (have_prev && !prev_ready) begin
        n_cmp++;
        if (now !== snap) begin
          n_err++;
          $display("FAIL stall_stable got=%h expected=%h", now, snap);
        end
      end
      snap = now; prev_ready = out_ready; have_prev = 1'b1;
      if (out_valid && out_ready && out_last) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    n_cmp++;
    if (cnt !== 14) begin
      n_err++;
      $display("FAIL stall_latency got=%0d expected=14", cnt);
    end
    out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int gap_exp, span_exp;
`ifdef MX_UNPACK_SKID_EN
    gap_exp = 0; span_exp = 15;
`else
    gap_exp = 1; span_exp = 16;
`endif
    out_ready = 1'b1;
    hs_cycs.delete();
    send_block(8'h20, 8'h00);
    send_block(8'h21, 8'h20);
    wait_drain();
    n_cmp++;
    if (hs_cycs.size() !== 16) begin
      n_err++;
      $display("FAIL b2b_count got=%0d expected=16", hs_cycs.size());
    end else begin
      n_cmp++;
      if (hs_cycs[8] - hs_cycs[7] - 1 !== gap_exp) begin
        n_err++;
        $display("FAIL b2b_gap got=%0d expected=%0d", hs_cycs[8] - hs_cycs[7] - 1, gap_exp);
      end
      n_cmp++;
      if (hs_cycs[15] - hs_cycs[0] !== span_exp) begin
        n_err++;
        $display("FAIL b2b_span got=%0d expected=%0d", hs_cycs[15] - hs_cycs[0], span_exp);
      end
    end
  endtask

  task automatic test_nan();
    logic [7:0] scs [2];
    scs[0] = 8'hFF; scs[1] = 8'h00;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send_block(scs[i], 8'h40);
      @(negedge clk);
      n_cmp++;
      if (out_scale_nan !== (i == 0)) begin
        n_err++;
        $display("FAIL nan_flag scale=%h got=%b expected=%b", scs[i], out_scale_nan, i == 0);
      end
      wait_drain();
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    out_ready = 1'b1;
    send_block(8'h11, 8'h80);
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (out_valid && out_beat_idx == 3'd3) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL rst_mid_find got=no_beat3 expected=beat3");
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_mid_valid got=%b expected=00", {out_valid, in_ready});
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_ready got=%b expected=1", in_ready);
    end
    send_block(8'h12, 8'h90);
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_beat_idx, out_first} !== 5'b1_000_1) begin
      n_err++;
      $display("FAIL rst_mid_restart got=%b expected=10001", {out_valid, out_beat_idx, out_first});
    end
    wait_drain();
  endtask

  task automatic test_wide();
    logic [127:0] blk;
    logic [7:0]   sc;
    bit           acc;
    w_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      blk = {$urandom, $urandom, $urandom, $urandom};
      sc  = (i == 2) ? 8'hFF : 8'($urandom_range(0, 254));
      w_in_elements = blk; w_in_scale = sc; w_in_valid = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++) begin
        @(negedge clk);
        if (w_in_ready) begin
          @(posedge clk);
          #1;
          acc = 1'b1;
        end
      end
      w_in_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({acc, w_out_valid, w_out_first, w_out_last, w_out_beat_idx, w_out_scale, w_out_scale_nan,
           w_out_elements} !== {5'b11110, sc, sc == 8'hFF, blk}) begin
        n_err++;
        $display("FAIL wide_beat got=%b_%h_%b_%h expected=%b_%h_%b_%h",
                 {acc, w_out_valid, w_out_first, w_out_last, w_out_beat_idx}, w_out_scale,
                 w_out_scale_nan, w_out_elements, 5'b11110, sc, sc == 8'hFF, blk);
      end
      @(negedge clk);
      n_cmp++;
      if (w_out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL wide_single got=%b expected=0", w_out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_nan();
    test_reset_mid();
    test_wide();
    repeat (3) @(posedge clk);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL leftover_beats got=%0d expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
